// File: rtl/pn_seq_gen.sv
// pn_seq_gen: parametrised Fibonacci LFSR m-sequence generator with runtime
// seed load, step enable, all-zero lock-up recovery, sequence-start sync pulse
// and a measured-period output. The parallel state doubles as a random word.
module pn_seq_gen #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b101),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             en,
    output logic             ser_out,
    output logic [WIDTH-1:0] state_out,
    output logic             sync,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lockup
);

    // Reject illegal configurations at elaboration time.
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("pn_seq_gen: WIDTH must be in 2..16");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("pn_seq_gen: SEED must be nonzero");
    end

    logic [WIDTH-1:0] state_q,  state_d;
    logic [WIDTH-1:0] seed_q,   seed_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             ser_q,    ser_d;
    logic             sync_q,   sync_d;
    logic             pvalid_q, pvalid_d;
    logic             lockup_q, lockup_d;

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] load_val;

    // Next-state logic: priority load > step (or zero-state recovery) > hold.
    always_comb begin
        fb       = ^(state_q & TAPS);
        shifted  = {state_q[WIDTH-2:0], fb};
        // A zero seed would lock the register, so the default seed replaces it.
        load_val = (seed_in == '0) ? SEED : seed_in;

        state_d  = state_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        ser_d    = ser_q;
        sync_d   = 1'b0;
        pvalid_d = pvalid_q;
        lockup_d = lockup_q;

        if (load) begin
            state_d  = load_val;
            seed_d   = load_val;
            ser_d    = 1'b0;
            cnt_d    = '0;
            lockup_d = 1'b0;
            pvalid_d = 1'b0;
        end else if (en) begin
            if (state_q != '0) begin
                ser_d   = state_q[WIDTH-1];
                state_d = shifted;
                if (shifted == seed_q) begin
                    sync_d   = 1'b1;
                    period_d = cnt_q + 1'b1;
                    pvalid_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end else begin
                // Only non-primitive taps can fall into the all-zero state.
                state_d  = seed_q;
                lockup_d = 1'b1;
                ser_d    = 1'b0;
                cnt_d    = '0;
            end
        end
    end

    // All generator state registers, asynchronously reset to the default seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEED;
            seed_q   <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            ser_q    <= 1'b0;
            sync_q   <= 1'b0;
            pvalid_q <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            ser_q    <= ser_d;
            sync_q   <= sync_d;
            pvalid_q <= pvalid_d;
            lockup_q <= lockup_d;
        end
    end

    assign ser_out      = ser_q;
    assign state_out    = state_q;
    assign sync         = sync_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign lockup       = lockup_q;

endmodule

// File: tb/tb_pn_seq_gen.sv
// tb_pn_seq_gen: directed bench for pn_seq_gen. Three instances: default
// 3-bit primitive, 3-bit non-primitive (TAPS=011), 7-bit primitive.
module tb_pn_seq_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst [3];
    logic        i_ld  [3];
    logic        i_en  [3];
    logic [15:0] i_sd  [3];

    logic       ser_a, sy_a, pv_a, lk_a;
    logic [2:0] st_a, per_a;
    logic       ser_b, sy_b, pv_b, lk_b;
    logic [2:0] st_b, per_b;
    logic       ser_c, sy_c, pv_c, lk_c;
    logic [6:0] st_c, per_c;

    pn_seq_gen u_a (
        .clk(clk), .reset(i_rst[0]), .load(i_ld[0]), .seed_in(i_sd[0][2:0]), .en(i_en[0]),
        .ser_out(ser_a), .state_out(st_a), .sync(sy_a), .period(per_a),
        .period_valid(pv_a), .lockup(lk_a)
    );

    pn_seq_gen #(.WIDTH(3), .TAPS(3'b011), .SEED(3'b001)) u_b (
        .clk(clk), .reset(i_rst[1]), .load(i_ld[1]), .seed_in(i_sd[1][2:0]), .en(i_en[1]),
        .ser_out(ser_b), .state_out(st_b), .sync(sy_b), .period(per_b),
        .period_valid(pv_b), .lockup(lk_b)
    );

    pn_seq_gen #(.WIDTH(7), .TAPS(7'b1100000), .SEED(7'd1)) u_c (
        .clk(clk), .reset(i_rst[2]), .load(i_ld[2]), .seed_in(i_sd[2][6:0]), .en(i_en[2]),
        .ser_out(ser_c), .state_out(st_c), .sync(sy_c), .period(per_c),
        .period_valid(pv_c), .lockup(lk_c)
    );

    typedef struct packed {
        logic [15:0] st;
        logic        ser;
        logic        sy;
        logic [15:0] per;
        logic        pv;
        logic        lk;
    } obs_t;

    obs_t  exp_q [$];
    string tag_q [$];
    int    tests = 0;
    int    fails = 0;

    // Reference model, one slot per instance
    int          mw    [3] = '{3, 3, 7};
    logic [15:0] m_st  [3];
    logic [15:0] m_seed[3];
    logic [15:0] m_cnt [3];
    logic [15:0] m_per [3];
    logic        m_ser [3];
    logic        m_sy  [3];
    logic        m_pv  [3];
    logic        m_lk  [3];

    // Successor states: instance 0 from the listed m-sequence, others by feedback taps
    function automatic logic [15:0] mnext(int d, logic [15:0] s);
        logic [15:0] r;
        r = 16'h0;
        if (d == 0) begin
            case (s[2:0])
                3'd1: r = 16'd3;
                3'd3: r = 16'd7;
                3'd7: r = 16'd6;
                3'd6: r = 16'd5;
                3'd5: r = 16'd2;
                3'd2: r = 16'd4;
                3'd4: r = 16'd1;
                default: r = 16'd0;
            endcase
        end else if (d == 1) begin
            r = {13'b0, s[1:0], s[1] ^ s[0]};
        end else begin
            r = {9'b0, s[5:0], s[6] ^ s[5]};
        end
        return r;
    endfunction

    task automatic model_reset(int d);
        m_st[d] = 16'd1; m_seed[d] = 16'd1; m_cnt[d] = 0; m_per[d] = 0;
        m_ser[d] = 0; m_sy[d] = 0; m_pv[d] = 0; m_lk[d] = 0;
    endtask

    task automatic model_edge(int d);
        logic [15:0] n, mask;
        mask = (16'd1 << mw[d]) - 16'd1;
        if (i_rst[d]) begin
            model_reset(d);
        end else if (i_ld[d]) begin
            n = i_sd[d] & mask;
            if (n == 0) n = 16'd1;
            m_st[d] = n; m_seed[d] = n; m_ser[d] = 0; m_sy[d] = 0;
            m_cnt[d] = 0; m_lk[d] = 0; m_pv[d] = 0;
        end else if (i_en[d]) begin
            if (m_st[d] != 0) begin
                m_ser[d] = m_st[d][mw[d]-1];
                n = mnext(d, m_st[d]);
                m_st[d] = n;
                if (n == m_seed[d]) begin
                    m_sy[d] = 1; m_per[d] = m_cnt[d] + 1; m_pv[d] = 1; m_cnt[d] = 0;
                end else begin
                    m_sy[d] = 0;
                    if (m_cnt[d] != mask) m_cnt[d] = m_cnt[d] + 1;
                end
            end else begin
                m_st[d] = m_seed[d]; m_lk[d] = 1; m_ser[d] = 0; m_sy[d] = 0; m_cnt[d] = 0;
            end
        end else begin
            m_sy[d] = 0;
        end
    endtask

    function automatic obs_t model_obs(int d);
        obs_t o;
        o.st = m_st[d]; o.ser = m_ser[d]; o.sy = m_sy[d];
        o.per = m_per[d]; o.pv = m_pv[d]; o.lk = m_lk[d];
        return o;
    endfunction

    function automatic obs_t dut_obs(int d);
        obs_t o;
        case (d)
            0: begin o.st = {13'b0, st_a}; o.ser = ser_a; o.sy = sy_a; o.per = {13'b0, per_a}; o.pv = pv_a; o.lk = lk_a; end
            1: begin o.st = {13'b0, st_b}; o.ser = ser_b; o.sy = sy_b; o.per = {13'b0, per_b}; o.pv = pv_b; o.lk = lk_b; end
            default: begin o.st = {9'b0, st_c}; o.ser = ser_c; o.sy = sy_c; o.per = {9'b0, per_c}; o.pv = pv_c; o.lk = lk_c; end
        endcase
        return o;
    endfunction

    // Pop one expected record and compare it with instance d
    task automatic check_out(int d);
        obs_t  e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = dut_obs(d);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed st=%h ser=%b sync=%b per=%h pv=%b lk=%b, expected st=%h ser=%b sync=%b per=%h pv=%b lk=%b",
                   t, o.st, o.ser, o.sy, o.per, o.pv, o.lk, e.st, e.ser, e.sy, e.per, e.pv, e.lk);
        end
    endtask

    // Drive one clock of stimulus to instance d, push expectation, compare after edge
    task automatic step(int d, logic ld, logic [15:0] sd, logic e, string tag);
        i_ld[d] = ld; i_sd[d] = sd; i_en[d] = e;
        for (int k = 0; k < 3; k++) model_edge(k);
        exp_q.push_back(model_obs(d));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out(d);
        i_ld[d] = 1'b0; i_en[d] = 1'b0;
    endtask

    // Single literal comparison against a directly known value
    task automatic lit(string tag, logic [15:0] obs, logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    logic [2:0] seq_tab [7] = '{3'd3, 3'd7, 3'd6, 3'd5, 3'd2, 3'd4, 3'd1};
    logic       ser_tab [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [9:0] en_pat = 10'b1101100111;   // seven enabled steps, LSB first
    int         nen;
    int         sync_step;

    initial begin
        for (int k = 0; k < 3; k++) begin
            i_rst[k] = 1'b1; i_ld[k] = 1'b0; i_en[k] = 1'b0; i_sd[k] = 16'h0;
            model_reset(k);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model_obs(k));
            tag_q.push_back("reset_state");
            check_out(k);
        end
        for (int k = 0; k < 3; k++) i_rst[k] = 1'b0;

        // Scenario 1: free run from default seed
        for (int i = 0; i < 14; i++) begin
            step(0, 1'b0, 16'h0, 1'b1, "s1_step");
            lit("s1_state", {13'b0, st_a}, {13'b0, seq_tab[i % 7]});
            lit("s1_ser", {15'b0, ser_a}, {15'b0, ser_tab[i % 7]});
            lit("s1_sync", {15'b0, sy_a}, (i % 7 == 6) ? 16'd1 : 16'd0);
        end
        lit("s1_period", {13'b0, per_a}, 16'd7);
        lit("s1_pvalid", {15'b0, pv_a}, 16'd1);

        // Scenario 2: seed 110
        step(0, 1'b1, 16'h6, 1'b1, "s2_load");
        lit("s2_load_state", {13'b0, st_a}, 16'h6);
        lit("s2_load_pvalid", {15'b0, pv_a}, 16'd0);
        for (int i = 0; i < 7; i++) step(0, 1'b0, 16'h0, 1'b1, "s2_step");
        lit("s2_sync", {15'b0, sy_a}, 16'd1);
        lit("s2_state", {13'b0, st_a}, 16'h6);
        lit("s2_period", {13'b0, per_a}, 16'd7);

        // Scenario 3: zero seed substitutes default
        step(0, 1'b1, 16'h0, 1'b0, "s3_load0");
        lit("s3_state", {13'b0, st_a}, 16'h1);
        lit("s3_lockup", {15'b0, lk_a}, 16'd0);
        for (int i = 0; i < 7; i++) begin
            step(0, 1'b0, 16'h0, 1'b1, "s3_step");
            lit("s3_seq", {13'b0, st_a}, {13'b0, seq_tab[i]});
        end

        // Back-to-back loads: last wins, no step in load cycles
        step(0, 1'b1, 16'h2, 1'b1, "b2b_load1");
        step(0, 1'b1, 16'h4, 1'b1, "b2b_load2");
        lit("b2b_state", {13'b0, st_a}, 16'h4);

        // Scenario 5: enable toggling mid-sequence
        nen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b0, 16'h0, en_pat[i], "s5_step");
            if (en_pat[i]) nen++;
            if (!en_pat[i]) lit("s5_nosync", {15'b0, sy_a}, 16'd0);
        end
        lit("s5_nen", nen[15:0], 16'd7);
        lit("s5_sync", {15'b0, sy_a}, 16'd1);
        lit("s5_period", {13'b0, per_a}, 16'd7);

        // Scenario 4: non-primitive taps, zero-state recovery
        step(1, 1'b1, 16'h4, 1'b0, "s4_load");
        step(1, 1'b0, 16'h0, 1'b1, "s4_to_zero");
        lit("s4_zero", {13'b0, st_b}, 16'h0);
        step(1, 1'b0, 16'h0, 1'b1, "s4_recover");
        lit("s4_rec_state", {13'b0, st_b}, 16'h4);
        lit("s4_rec_lockup", {15'b0, lk_b}, 16'd1);
        lit("s4_rec_ser", {15'b0, ser_b}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b0, 16'h0, 1'b1, "s4_more");
            lit("s4_sticky", {15'b0, lk_b}, 16'd1);
            lit("s4_nosync", {15'b0, sy_b}, 16'd0);
        end
        // Off-cycle seed: load clears lockup, sync never fires
        step(1, 1'b1, 16'h0, 1'b0, "s4_load0");
        lit("s4_lk_clear", {15'b0, lk_b}, 16'd0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1'b0, 16'h0, 1'b1, "s4_offcycle");
            lit("s4_off_nosync", {15'b0, sy_b}, 16'd0);
        end

        // Scenario 6: 7-bit primitive, period 127, reset mid-sequence
        sync_step = 0;
        for (int i = 1; i <= 127; i++) begin
            step(2, 1'b0, 16'h0, 1'b1, "s6_step");
            if (sy_c === 1'b1 && sync_step == 0) sync_step = i;
        end
        lit("s6_first_sync", sync_step[15:0], 16'd127);
        lit("s6_period", {9'b0, per_c}, 16'd127);
        for (int i = 0; i < 50; i++) step(2, 1'b0, 16'h0, 1'b1, "s6_pre_reset");
        i_rst[2] = 1'b1;
        #1;
        model_reset(2);
        exp_q.push_back(model_obs(2));
        tag_q.push_back("s6_async_reset");
        check_out(2);
        lit("s6_rst_state", {9'b0, st_c}, 16'd1);
        step(2, 1'b0, 16'h0, 1'b1, "s6_in_reset");
        i_rst[2] = 1'b0;
        sync_step = 0;
        for (int i = 1; i <= 127; i++) begin
            step(2, 1'b0, 16'h0, 1'b1, "s6_after_reset");
            if (sy_c === 1'b1 && sync_step == 0) sync_step = i;
        end
        lit("s6_resync", sync_step[15:0], 16'd127);
        lit("s6_period2", {9'b0, per_c}, 16'd127);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pn_seq_gen.md
Name: pn_seq_gen

Overview:
Parametrised Fibonacci LFSR maximal-length (m-sequence) generator. Successor to the fixed 3-bit serial m-sequence source. Adds width/tap parametrisation, runtime seed load, step enable, all-zero lock-up recovery, a sequence-start sync pulse and a measured-period output. Feeds the DDS modulation path as a PN/data-bit source; its parallel state doubles as a pseudo-random word.

Parameters:
WIDTH, 3, LFSR length in bits (legal 2..16)
TAPS, 3'b101, feedback mask (WIDTH bits); feedback bit = XOR of state bits where TAPS bit is 1
SEED, 1, default seed (WIDTH bits, must be nonzero); used at reset and whenever a zero seed is loaded

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load  input  1  seed load strobe; priority over en
seed_in  input  WIDTH  seed value sampled when load=1
en  input  1  step enable; one LFSR step per cycle with en=1
ser_out  output  1  registered serial PN bit
state_out  output  WIDTH  current LFSR state (direct register view)
sync  output  1  one-cycle pulse when the state returns to the active seed
period  output  WIDTH  step count of the last completed sequence period
period_valid  output  1  set after the first completed period; cleared by reset/load
lockup  output  1  sticky flag: all-zero state detected and recovered

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. All state is in one registered block.
- Reset values:
  - state = SEED; seed_reg = SEED.
  - ser_out, sync, lockup, period_valid = 0; period = 0; step_cnt = 0.
- Next state: fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb} (shift toward MSB, feedback into LSB).
- Priority: reset > load > en > hold.
- load=1 (en ignored):
  - seed_reg and state <= seed_in, or SEED if seed_in == 0.
  - ser_out <= 0; sync <= 0; step_cnt <= 0.
  - lockup <= 0; period_valid <= 0; period holds its value.
- en=1, load=0, state != 0:
  - ser_out <= state[WIDTH-1] (MSB before the shift); state <= next.
  - If next == seed_reg: sync <= 1; period <= step_cnt+1; period_valid <= 1; step_cnt <= 0.
  - Otherwise: sync <= 0; step_cnt <= step_cnt+1, saturating at all-ones. No sync when the seed is off-cycle for a non-primitive TAPS.
- en=1, load=0, state == 0 (reachable only with non-primitive TAPS):
  - state <= seed_reg; lockup <= 1; ser_out <= 0.
  - sync <= 0; step_cnt <= 0.
- en=0, load=0: state, ser_out, step_cnt, period, lockup hold; sync <= 0.
- Latency: ser_out and sync change on the clock edge that performs the step; ser_out shows the pre-step MSB.
- Period value: with primitive TAPS, period = 2^WIDTH - 1 for any nonzero seed.
- Reset mid-sequence: immediate return to reset values; the next period is measured from SEED.
- Back-to-back load: the last load wins; a step is never taken in a load cycle.
- Parameter check: SEED == 0 or WIDTH < 2 is an elaboration error.

Test Plan:
1. Default params, release reset, en=1 for 14 cycles:
   - state sequence 001,011,111,110,101,010,100,001 repeating.
   - ser_out after each step: 0,0,1,1,1,0,1 repeating.
   - sync on the 7th and 14th steps; period=7 and period_valid=1 from the 7th step.
2. load=1 with seed_in=3'b110, then en=1:
   - Sequence starts 110,101,010,…
   - sync when state returns to 110 after 7 steps; period=7.
3. load with seed_in=0:
   - state=001 (SEED substituted); lockup=0.
   - Sequence identical to scenario 1.
4. TAPS=3'b011 (non-primitive), seed 3'b100, en=1:
   - state 100→000 (fb=0).
   - Next en cycle: state=100, lockup=1 and stays 1; no sync; ser_out=0 on the recovery cycle.
5. en toggled 1,0,0,1 mid-sequence:
   - state/ser_out/step_cnt frozen during en=0; sync never asserted while en=0.
   - period still 7 on completion.
6. WIDTH=7, TAPS=7'b1100000, SEED=1, en=1 continuously:
   - first sync after 127 steps; period=127.
   - Assert reset at step 50: all outputs at reset values immediately; sync again 127 steps after release.
